// File: rtl/register_file.sv
// Architectural register file for the 16-bit single-cycle MIPS datapath: two combinational
// read ports, one registered write port, a debug read port. Optional macro: REGFILE_BYPASS_EN.
module register_file #(
    parameter int          N       = 16,
    parameter int          ADDR_W  = 3,
    parameter int          SP_IDX  = 7,
    parameter logic [N-1:0] SP_INIT = 16'h00FE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [N-1:0]      ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [N-1:0]      rb_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [N-1:0]      wd_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data
);

    localparam int REGS = 2 ** ADDR_W;

    logic [N-1:0] regs [REGS];
    logic         wr_valid;
    logic [N-1:0] ra_stored;
    logic [N-1:0] rb_stored;

    assign wr_valid = we && (wa_addr != '0);

    // Reset wins over a same-cycle write; the stack pointer comes out of reset pre-loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_valid) begin
            regs[wa_addr] <= wd_data;
        end
    end

    always_comb begin
        ra_stored = (ra_addr == '0) ? '0 : regs[ra_addr];
        rb_stored = (rb_addr == '0) ? '0 : regs[rb_addr];
        dbg_data  = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

`ifdef REGFILE_BYPASS_EN
    // Write-first: forward the incoming write data to a read port that addresses the same register.
    always_comb begin
        ra_data = (wr_valid && (ra_addr == wa_addr)) ? wd_data : ra_stored;
        rb_data = (wr_valid && (rb_addr == wa_addr)) ? wd_data : rb_stored;
    end
`else
    always_comb begin
        ra_data = ra_stored;
        rb_data = rb_stored;
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (we) begin
            assert (!$isunknown({wa_addr, wd_data}))
            else $error("register_file: write with unknown address or data");
        end
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow REGFILE_BYPASS_EN if defined.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [2:0]  ra_addr;
    logic [15:0] ra_data;
    logic [2:0]  rb_addr;
    logic [15:0] rb_data;
    logic        we;
    logic [2:0]  wa_addr;
    logic [15:0] wd_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int tests_run;
    int tests_failed;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (ra_addr),
        .ra_data  (ra_data),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data),
        .we       (we),
        .wa_addr  (wa_addr),
        .wd_data  (wd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so they are stable well before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        we      = 1'b1;
        wa_addr = a;
        wd_data = d;
        tick();
        we      = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        rst     = 1'b1;
        we      = 1'b1;
        wa_addr = 3'd3;
        wd_data = 16'h1234;
        tick();
        rst = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            exp = (i == 7) ? 16'h00FE : 16'h0000;
            tests_run++;
            if (dbg_data !== exp) begin
                $display("[TB] FAIL reset_reg%0d got %h expected %h", i, dbg_data, exp);
                tests_failed++;
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(3'd2, 16'hA5A5);
        write_reg(3'd5, 16'h0F0F);
        ra_addr = 3'd2;
        rb_addr = 3'd5;
        #1;
        tests_run++;
        if (ra_data !== 16'hA5A5) begin
            $display("[TB] FAIL wr_ra2 got %h expected %h", ra_data, 16'hA5A5);
            tests_failed++;
        end
        tests_run++;
        if (rb_data !== 16'h0F0F) begin
            $display("[TB] FAIL wr_rb5 got %h expected %h", rb_data, 16'h0F0F);
            tests_failed++;
        end
        ra_addr = 3'd5;
        #1;
        tests_run++;
        if (ra_data !== 16'h0F0F) begin
            $display("[TB] FAIL same_ra5 got %h expected %h", ra_data, 16'h0F0F);
            tests_failed++;
        end
        tests_run++;
        if (rb_data !== 16'h0F0F) begin
            $display("[TB] FAIL same_rb5 got %h expected %h", rb_data, 16'h0F0F);
            tests_failed++;
        end
    endtask

    task automatic test_r0();
        write_reg(3'd0, 16'hFFFF);
        ra_addr  = 3'd0;
        rb_addr  = 3'd0;
        dbg_addr = 3'd0;
        #1;
        tests_run++;
        if (ra_data !== 16'h0000) begin
            $display("[TB] FAIL r0_ra got %h expected %h", ra_data, 16'h0000);
            tests_failed++;
        end
        tests_run++;
        if (rb_data !== 16'h0000) begin
            $display("[TB] FAIL r0_rb got %h expected %h", rb_data, 16'h0000);
            tests_failed++;
        end
        tests_run++;
        if (dbg_data !== 16'h0000) begin
            $display("[TB] FAIL r0_dbg got %h expected %h", dbg_data, 16'h0000);
            tests_failed++;
        end
        // A write to r0 with a matching read address must never be forwarded.
        we      = 1'b1;
        wa_addr = 3'd0;
        wd_data = 16'hBEEF;
        #1;
        tests_run++;
        if (ra_data !== 16'h0000) begin
            $display("[TB] FAIL r0_nobypass got %h expected %h", ra_data, 16'h0000);
            tests_failed++;
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_bypass();
        logic [15:0] exp_before;
`ifdef REGFILE_BYPASS_EN
        exp_before = 16'h2222;
`else
        exp_before = 16'h1111;
`endif
        write_reg(3'd4, 16'h1111);
        we       = 1'b1;
        wa_addr  = 3'd4;
        wd_data  = 16'h2222;
        ra_addr  = 3'd4;
        rb_addr  = 3'd4;
        dbg_addr = 3'd4;
        #1;
        tests_run++;
        if (ra_data !== exp_before) begin
            $display("[TB] FAIL rdw_ra_before got %h expected %h", ra_data, exp_before);
            tests_failed++;
        end
        tests_run++;
        if (rb_data !== exp_before) begin
            $display("[TB] FAIL rdw_rb_before got %h expected %h", rb_data, exp_before);
            tests_failed++;
        end
        tests_run++;
        if (dbg_data !== 16'h1111) begin
            $display("[TB] FAIL rdw_dbg_before got %h expected %h", dbg_data, 16'h1111);
            tests_failed++;
        end
        tick();
        we = 1'b0;
        #1;
        tests_run++;
        if (ra_data !== 16'h2222) begin
            $display("[TB] FAIL rdw_ra_after got %h expected %h", ra_data, 16'h2222);
            tests_failed++;
        end
    endtask

    task automatic test_midrun_reset();
        logic [15:0] exp;
        for (int i = 1; i < 8; i++) begin
            write_reg(3'(i), 16'(16'h0101 * i));
        end
        dbg_addr = 3'd7;
        #1;
        tests_run++;
        if (dbg_data !== 16'h0707) begin
            $display("[TB] FAIL sp_write got %h expected %h", dbg_data, 16'h0707);
            tests_failed++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            exp = (i == 7) ? 16'h00FE : 16'h0000;
            tests_run++;
            if (dbg_data !== exp) begin
                $display("[TB] FAIL midrst_reg%0d got %h expected %h", i, dbg_data, exp);
                tests_failed++;
            end
        end
        write_reg(3'd1, 16'h0042);
        dbg_addr = 3'd1;
        #1;
        tests_run++;
        if (dbg_data !== 16'h0042) begin
            $display("[TB] FAIL post_rst_write got %h expected %h", dbg_data, 16'h0042);
            tests_failed++;
        end
    endtask

    task automatic test_we_low();
        write_reg(3'd6, 16'h6666);
        we      = 1'b0;
        wa_addr = 3'd6;
        wd_data = 16'hDEAD;
        ra_addr = 3'd6;
        repeat (4) tick();
        dbg_addr = 3'd6;
        #1;
        tests_run++;
        if (dbg_data !== 16'h6666) begin
            $display("[TB] FAIL we_low_dbg got %h expected %h", dbg_data, 16'h6666);
            tests_failed++;
        end
        tests_run++;
        if (ra_data !== 16'h6666) begin
            $display("[TB] FAIL we_low_ra got %h expected %h", ra_data, 16'h6666);
            tests_failed++;
        end
    endtask

    task automatic test_back_to_back();
        we      = 1'b1;
        wa_addr = 3'd3;
        wd_data = 16'h0003;
        tick();
        wd_data = 16'h0333;
        tick();
        wa_addr = 3'd2;
        wd_data = 16'hC0DE;
        tick();
        we      = 1'b0;
        ra_addr = 3'd3;
        rb_addr = 3'd2;
        #1;
        tests_run++;
        if (ra_data !== 16'h0333) begin
            $display("[TB] FAIL b2b_ra3 got %h expected %h", ra_data, 16'h0333);
            tests_failed++;
        end
        tests_run++;
        if (rb_data !== 16'hC0DE) begin
            $display("[TB] FAIL b2b_rb2 got %h expected %h", rb_data, 16'hC0DE);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        we       = 1'b0;
        ra_addr  = '0;
        rb_addr  = '0;
        wa_addr  = '0;
        wd_data  = '0;
        dbg_addr = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_midrun_reset();
        test_we_low();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
